uart_rx: RTL and testbench

// - UART receiver, 8N1 framing, LSB first; counterpart of the project's uart_tx.
// - Samples asynchronous rx_serial line, recovers bytes, presents each on rx_data with a 1-cycle rx_valid strobe.
// - Flags framing errors (stop bit sampled low) and overruns (new byte completes while previous unread).
// - Sits between the board RX pin and the consumer logic (loopback tests, command parser).

---
 rtl/uart_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_rx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, with sticky framing/overrun flags.
// Define UART_RX_PARITY_EN for 8E1 framing with an extra parity_err output.
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       rx_serial,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state;
    logic             rx_meta;
    logic             rx_sync;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
`ifdef UART_RX_PARITY_EN
    logic             par_bit;
`endif

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_ready  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            if (rx_ack) begin
                rx_ready  <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err <= 1'b0;
`endif
            end

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_sync) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt <= '0;
                        if (!rx_sync) begin
                            state <= DATA;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == CNT_FULL) begin
                        clk_cnt        <= '0;
                        shift[bit_idx] <= rx_sync;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (clk_cnt == CNT_FULL) begin
                        clk_cnt <= '0;
                        par_bit <= rx_sync;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (clk_cnt == CNT_FULL) begin
                        // Completion outranks a same-cycle ack: the ack clears old state first
                        clk_cnt   <= '0;
                        state     <= IDLE;
                        rx_busy   <= 1'b0;
                        rx_data   <= shift;
                        rx_valid  <= 1'b1;
                        rx_ready  <= 1'b1;
                        frame_err <= (frame_err & ~rx_ack) | ~rx_sync;
                        overrun   <= (overrun & ~rx_ack) | (rx_ready & ~rx_ack);
`ifdef UART_RX_PARITY_EN
                        parity_err <= (parity_err & ~rx_ack) | (^{shift, par_bit});
`endif
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at default 434 clocks per bit.
// Honours UART_RX_PARITY_EN to exercise the 8E1 build.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 434;
`ifdef UART_RX_PARITY_EN
    localparam int NOM_LAT    = 4126 + CPB;
    localparam int BREAK_HOLD = 9200;
`else
    localparam int NOM_LAT    = 4126;
    localparam int BREAK_HOLD = 8400;
`endif

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       rx_serial = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready, rx_busy, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int last_cyc = 0;
    int t_start = 0;
    int lat = NOM_LAT;

    uart_rx dut (
        .clk       (clk),
        .rst_      (rst_),
        .rx_serial (rx_serial),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            valid_cnt <= valid_cnt + 1;
            last_cyc  <= cyc;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_serial = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        t_start = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) rx_serial = 1'b1;
`endif
        send_bit(stop_bit);
        rx_serial = 1'b1;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        idle(5);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", rx_data); end
        checks++; if ({rx_valid, rx_ready, rx_busy, frame_err, overrun} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {rx_valid, rx_ready, rx_busy, frame_err, overrun}); end
        rst_ = 1'b1;
        idle(5);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", rx_busy); end
    endtask

    task automatic test_basic();
        int n0, l;
        n0 = valid_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(CPB);
        l = last_cyc - t_start;
        checks++; if (valid_cnt - n0 !== 1) begin errors++; $display("FAIL basic_strobes got %0d want 1", valid_cnt - n0); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h want a5", rx_data); end
        checks++; if ({rx_ready, frame_err, overrun, rx_busy} !== 4'b1000) begin
            errors++; $display("FAIL basic_flags got %b want 1000", {rx_ready, frame_err, overrun, rx_busy}); end
        checks++; if (l < NOM_LAT - 6 || l > NOM_LAT + 6) begin
            errors++; $display("FAIL basic_latency got %0d want %0d+-6", l, NOM_LAT); end
        else lat = l;
        pulse_ack();
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL basic_ack got %b want 0", rx_ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got [2];
        int n0;
        got[0] = 8'h55; got[1] = 8'h55;
        n0 = valid_cnt;
        fork
            begin
                send_frame(8'h00, 1'b1, 1'b0);
                send_frame(8'hFF, 1'b1, 1'b0);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    int w = 0;
                    while (rx_valid !== 1'b1 && w < 6000) begin @(negedge clk); w++; end
                    if (rx_valid === 1'b1) got[k] = rx_data;
                    rx_ack = 1'b1;
                    @(negedge clk);
                    rx_ack = 1'b0;
                end
            end
        join
        idle(CPB);
        checks++; if (valid_cnt - n0 !== 2) begin errors++; $display("FAIL b2b_strobes got %0d want 2", valid_cnt - n0); end
        checks++; if (got[0] !== 8'h00) begin errors++; $display("FAIL b2b_first got %h want 00", got[0]); end
        checks++; if (got[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h want ff", got[1]); end
        checks++; if ({overrun, frame_err, rx_ready} !== 3'b000) begin
            errors++; $display("FAIL b2b_flags got %b want 000", {overrun, frame_err, rx_ready}); end
    endtask

    task automatic test_frame_err();
        int n0;
        n0 = valid_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(2 * CPB);
        checks++; if (valid_cnt - n0 !== 1) begin errors++; $display("FAIL ferr_strobes got %0d want 1", valid_cnt - n0); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL ferr_data got %h want 3c", rx_data); end
        checks++; if ({frame_err, rx_ready, rx_busy} !== 3'b110) begin
            errors++; $display("FAIL ferr_flags got %b want 110", {frame_err, rx_ready, rx_busy}); end
        pulse_ack();
        checks++; if ({frame_err, rx_ready} !== 2'b00) begin
            errors++; $display("FAIL ferr_ack got %b want 00", {frame_err, rx_ready}); end
    endtask

    task automatic test_overrun();
        int n0;
        n0 = valid_cnt;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(CPB);
        checks++; if (valid_cnt - n0 !== 2) begin errors++; $display("FAIL ovr_strobes got %0d want 2", valid_cnt - n0); end
        checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL ovr_data got %h want 22", rx_data); end
        checks++; if ({overrun, rx_ready, frame_err} !== 3'b110) begin
            errors++; $display("FAIL ovr_flags got %b want 110", {overrun, rx_ready, frame_err}); end
        pulse_ack();
        checks++; if ({overrun, rx_ready} !== 2'b00) begin
            errors++; $display("FAIL ovr_ack got %b want 00", {overrun, rx_ready}); end
    endtask

    task automatic test_glitch();
        int n0;
        n0 = valid_cnt;
        rx_serial = 1'b0;
        idle(10);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_early got %b want 1", rx_busy); end
        idle(90);
        rx_serial = 1'b1;
        idle(100);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_pre_mid got %b want 1", rx_busy); end
        idle(30);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_post_mid got %b want 0", rx_busy); end
        idle(12 * CPB);
        checks++; if (valid_cnt - n0 !== 0 || rx_ready !== 1'b0) begin
            errors++; $display("FAIL glitch_nostrobe got %0d/%b want 0/0", valid_cnt - n0, rx_ready); end
    endtask

    task automatic test_ack_collision();
        send_frame(8'h81, 1'b1, 1'b0);
        idle(CPB);
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL coll_pre_ready got %b want 1", rx_ready); end
        fork
            send_frame(8'h7E, 1'b1, 1'b0);
            begin
                int t0;
                t0 = cyc;
                while (cyc - t0 < lat - 1) @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
                checks++; if ({rx_valid, rx_ready, overrun} !== 3'b110) begin
                    errors++; $display("FAIL coll_flags got %b want 110", {rx_valid, rx_ready, overrun}); end
                checks++; if (rx_data !== 8'h7E) begin errors++; $display("FAIL coll_data got %h want 7e", rx_data); end
            end
        join
        idle(CPB);
        checks++; if ({rx_ready, overrun} !== 2'b10) begin
            errors++; $display("FAIL coll_post got %b want 10", {rx_ready, overrun}); end
        pulse_ack();
    endtask

    task automatic test_break();
        logic [7:0] d [2];
        logic       fe [2];
        int         n;
        n = 0;
        d[0] = 8'h55; d[1] = 8'h55; fe[0] = 1'b0; fe[1] = 1'b0;
        fork
            begin
                rx_serial = 1'b0;
                idle(BREAK_HOLD);
                rx_serial = 1'b1;
            end
            begin
                for (int w = 0; w < BREAK_HOLD + 3 * CPB; w++) begin
                    @(negedge clk);
                    if (rx_valid === 1'b1) begin
                        if (n < 2) begin d[n] = rx_data; fe[n] = frame_err; end
                        n++;
                    end
                end
            end
        join
        checks++; if (n !== 2) begin errors++; $display("FAIL break_strobes got %0d want 2", n); end
        checks++; if ({d[0], fe[0]} !== {8'h00, 1'b1}) begin
            errors++; $display("FAIL break_first got %h/%b want 00/1", d[0], fe[0]); end
        checks++; if ({d[1], fe[1]} !== {8'h00, 1'b1}) begin
            errors++; $display("FAIL break_second got %h/%b want 00/1", d[1], fe[1]); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL break_idle got %b want 0", rx_busy); end
        pulse_ack();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        int n0;
        d = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx_serial = d[4];
        idle(CPB / 2);
        rst_ = 1'b0;
        rx_serial = 1'b1;
        idle(4);
        checks++; if ({rx_busy, rx_valid, rx_data} !== 10'h000) begin
            errors++; $display("FAIL rstmid_in_reset got %b/%b/%h want 0/0/00", rx_busy, rx_valid, rx_data); end
        rst_ = 1'b1;
        n0 = valid_cnt;
        idle(3 * CPB);
        checks++; if (valid_cnt - n0 !== 0) begin errors++; $display("FAIL rstmid_no_strobe got %0d want 0", valid_cnt - n0); end
        send_frame(8'hC3, 1'b1, 1'b0);
        idle(CPB);
        checks++; if (valid_cnt - n0 !== 1 || rx_data !== 8'hC3) begin
            errors++; $display("FAIL rstmid_data got %0d/%h want 1/c3", valid_cnt - n0, rx_data); end
        checks++; if ({rx_ready, frame_err, overrun} !== 3'b100) begin
            errors++; $display("FAIL rstmid_flags got %b want 100", {rx_ready, frame_err, overrun}); end
        pulse_ack();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h07, 1'b1, 1'b1);
        idle(CPB);
        checks++; if ({rx_data, parity_err} !== {8'h07, 1'b1}) begin
            errors++; $display("FAIL parity_bad got %h/%b want 07/1", rx_data, parity_err); end
        pulse_ack();
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_ack got %b want 0", parity_err); end
        send_frame(8'h07, 1'b1, 1'b0);
        idle(CPB);
        checks++; if ({rx_data, parity_err, rx_ready} !== {8'h07, 1'b0, 1'b1}) begin
            errors++; $display("FAIL parity_good got %h/%b/%b want 07/0/1", rx_data, parity_err, rx_ready); end
        pulse_ack();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_ack_collision();
        test_break();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
